// File: rtl/semafor_ped_ctrl.sv
// rtl/semafor_ped_ctrl.sv - pedestrian-crossing traffic-light controller
module semafor_ped_ctrl #(
    parameter int CNT_W      = 16,
    parameter int G_MIN      = 20,
    parameter int T_YELLOW   = 3,
    parameter int T_CLEAR    = 2,
    parameter int T_PED      = 10,
    parameter int T_BLINK    = 6,
    parameter int BLINK_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    output logic car_red,
    output logic car_yellow,
    output logic car_green,
    output logic ped_red,
    output logic ped_green,
    output logic ped_wait
);

    localparam longint T_MAX = longint'(1) << CNT_W;

    if (CNT_W < 1 || CNT_W > 32 ||
        G_MIN < 1 || T_YELLOW < 1 || T_CLEAR < 1 || T_PED < 1 || T_BLINK < 1 || BLINK_HALF < 1 ||
        G_MIN > T_MAX || T_YELLOW > T_MAX || T_CLEAR > T_MAX ||
        T_PED > T_MAX || T_BLINK > T_MAX || BLINK_HALF > T_MAX) begin : g_param_check
        $error("semafor_ped_ctrl: timing parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(G_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LOAD    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] PED_LOAD  = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] BLK_LOAD  = CNT_W'(T_BLINK - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BLINK_HALF - 1);

    // lamp vector order: car_red, car_yellow, car_green, ped_red, ped_green
    localparam logic [4:0] LAMP_GREEN  = 5'b00110;
    localparam logic [4:0] LAMP_YELLOW = 5'b01010;
    localparam logic [4:0] LAMP_ALLRED = 5'b10010;
    localparam logic [4:0] LAMP_PED    = 5'b10001;

    typedef enum logic [2:0] {
        S_CAR_GREEN  = 3'd0,
        S_CAR_YELLOW = 3'd1,
        S_ALL_RED1   = 3'd2,
        S_PED_GREEN  = 3'd3,
        S_PED_BLINK  = 3'd4,
        S_ALL_RED2   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic             ped_wait_q, ped_wait_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [4:0]       lamps_q, lamps_d;
    logic             rise;

    assign rise = sync2_q & ~prev_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = (timer_q == '0) ? '0 : timer_q - 1'b1;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        ped_wait_d  = ped_wait_q;
        case (state_q)
            S_CAR_GREEN: begin
                if (rise) ped_wait_d = 1'b1;
                if (timer_q == '0 && ped_wait_q) begin
                    state_d = S_CAR_YELLOW;
                    timer_d = Y_LOAD;
                end
            end
            S_CAR_YELLOW: begin
                if (timer_q == '0) begin
                    state_d = S_ALL_RED1;
                    timer_d = CLR_LOAD;
                end
            end
            S_ALL_RED1: begin
                if (timer_q == '0) begin
                    state_d    = S_PED_GREEN;
                    timer_d    = PED_LOAD;
                    ped_wait_d = 1'b0;
                end
            end
            S_PED_GREEN: begin
                if (timer_q == '0) begin
                    state_d     = S_PED_BLINK;
                    timer_d     = BLK_LOAD;
                    blink_d     = 1'b1;
                    blink_cnt_d = HALF_LOAD;
                end
            end
            S_PED_BLINK: begin
                if (blink_cnt_q == '0) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = HALF_LOAD;
                end else begin
                    blink_cnt_d = blink_cnt_q - 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = S_ALL_RED2;
                    timer_d = CLR_LOAD;
                end
            end
            S_ALL_RED2: begin
                if (timer_q == '0) begin
                    state_d = S_CAR_GREEN;
                    timer_d = G_LOAD;
                end
            end
            default: begin
                state_d    = S_CAR_GREEN;
                timer_d    = G_LOAD;
                ped_wait_d = 1'b0;
            end
        endcase
    end

    // lamps are decoded from the next state so the lamp register tracks state_q exactly
    always_comb begin
        lamps_d = LAMP_GREEN;
        case (state_d)
            S_CAR_GREEN:  lamps_d = LAMP_GREEN;
            S_CAR_YELLOW: lamps_d = LAMP_YELLOW;
            S_ALL_RED1:   lamps_d = LAMP_ALLRED;
            S_PED_GREEN:  lamps_d = LAMP_PED;
            S_PED_BLINK:  lamps_d = {4'b1000, blink_d};
            S_ALL_RED2:   lamps_d = LAMP_ALLRED;
            default:      lamps_d = LAMP_GREEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CAR_GREEN;
            timer_q     <= G_LOAD;
            blink_cnt_q <= HALF_LOAD;
            blink_q     <= 1'b1;
            ped_wait_q  <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            lamps_q     <= LAMP_GREEN;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            ped_wait_q  <= ped_wait_d;
            sync1_q     <= ped_req;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            lamps_q     <= lamps_d;
        end
    end

    assign car_red    = lamps_q[4];
    assign car_yellow = lamps_q[3];
    assign car_green  = lamps_q[2];
    assign ped_red    = lamps_q[1];
    assign ped_green  = lamps_q[0];
    assign ped_wait   = ped_wait_q;

endmodule
